// File: rtl/gray_count_gen.sv
// rtl/gray_count_gen.sv - registered up/down Gray-code counter with load, wrap pulse and valid/ready hold
//
// Ports:
//   clk        rising-edge clock for all state
//   rst        synchronous active-high reset; clears count, outputs and out_valid
//   en         count enable
//   up         direction, 1 = increment, 0 = decrement
//   load       synchronous load of load_bin; wins over counting
//   load_bin   binary value to load (SIZE bits)
//   gray       registered Gray code of the count (SIZE bits)
//   bin        registered binary count (SIZE bits)
//   out_valid  gray/bin hold a presentable code
//   out_ready  downstream has consumed the current code
//   wrap       one-cycle pulse when a step rolls over terminal count
//
// SIZE is intended for 2..32.

module gray_count_gen #(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            up,
  input  logic            load,
  input  logic [SIZE-1:0] load_bin,
  output logic [SIZE-1:0] gray,
  output logic [SIZE-1:0] bin,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            wrap
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  localparam logic [SIZE-1:0] ALL_ONES = '1;
  localparam logic [SIZE-1:0] ALL_ZERO = '0;
  localparam logic [SIZE-1:0] ONE      = {{(SIZE-1){1'b0}}, 1'b1};

  logic            state;
  logic [SIZE-1:0] b_q;
  logic [SIZE-1:0] b_next;
  logic [SIZE-1:0] gray_next;
  logic            wrap_next;
  logic            step;

  // A step needs a code already presented (RUN) and consumed downstream;
  // load always pre-empts it.
  assign step = en & (state == ST_RUN) & out_ready & ~load;

  always_comb begin
    b_next    = b_q;
    wrap_next = 1'b0;
    if (load) begin
      b_next = load_bin;
    end else if (step) begin
      if (up) begin
        b_next    = b_q + ONE;
        wrap_next = (b_q == ALL_ONES);
      end else begin
        b_next    = b_q - ONE;
        wrap_next = (b_q == ALL_ZERO);
      end
    end
    // Gray is computed from the next binary value so both outputs
    // are plain registers with no input-to-output path.
    gray_next = b_next ^ (b_next >> 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      b_q   <= '0;
      gray  <= '0;
      wrap  <= 1'b0;
    end else begin
      // IDLE lasts exactly one cycle after reset; RUN holds until reset.
      case (state)
        ST_IDLE: state <= ST_RUN;
        default: state <= ST_RUN;
      endcase
      b_q  <= b_next;
      gray <= gray_next;
      wrap <= wrap_next;
    end
  end

  assign bin       = b_q;
  assign out_valid = (state == ST_RUN);

endmodule

// File: tb/tb_gray_count_gen.sv
// tb/tb_gray_count_gen.sv - directed and randomized checks of gray_count_gen at SIZE=4 and SIZE=8

module tb_gray_count_gen;

  logic       clk = 1'b0;
  logic       rst, en, up, load, out_ready;
  logic [3:0] lb4;
  logic [7:0] lb8;
  logic [3:0] gray4, bin4;
  logic [7:0] gray8, bin8;
  logic       v4, v8, wrap4, wrap8;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  gray_count_gen #(.SIZE(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_bin(lb4),
    .gray(gray4), .bin(bin4), .out_valid(v4), .out_ready(out_ready), .wrap(wrap4)
  );

  gray_count_gen #(.SIZE(8)) dut8 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_bin(lb8),
    .gray(gray8), .bin(bin8), .out_valid(v8), .out_ready(out_ready), .wrap(wrap8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [3:0] g4_tab [0:16];
  logic [7:0] m_b, prev_g;
  logic       m_v, m_w, m_step;

  initial begin
    g4_tab = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
               4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

    // Reset state
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; out_ready = 1'b0;
    lb4 = 4'h0; lb8 = 8'h00;
    tick(); tick();
    chk("rst_gray4", 32'(gray4), 32'h0);
    chk("rst_bin4",  32'(bin4),  32'h0);
    chk("rst_v4",    32'(v4),    32'h0);
    chk("rst_wrap4", 32'(wrap4), 32'h0);
    chk("rst_v8",    32'(v8),    32'h0);

    // First cycle after release ignores en/out_ready
    rst = 1'b0; en = 1'b1; up = 1'b1; out_ready = 1'b1;
    chk("idle_v4", 32'(v4), 32'h0);
    tick();
    chk("run_v4",   32'(v4),   32'h1);
    chk("run_bin4", 32'(bin4), 32'h0);

    // 16 up steps through the full 4-bit Gray sequence
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk($sformatf("seq_gray4_%0d", k), 32'(gray4), 32'(g4_tab[k]));
      chk($sformatf("seq_bin4_%0d", k),  32'(bin4),  32'(k % 16));
      chk($sformatf("seq_wrap4_%0d", k), 32'(wrap4), (k == 16) ? 32'h1 : 32'h0);
    end

    // Load 0 then count down once: underflow wrap
    load = 1'b1; lb4 = 4'h0;
    tick();
    chk("ld0_bin4",  32'(bin4),  32'h0);
    chk("ld0_wrap4", 32'(wrap4), 32'h0);
    load = 1'b0; up = 1'b0;
    tick();
    chk("dn_bin4",  32'(bin4),  32'hF);
    chk("dn_gray4", 32'(gray4), 32'h8);
    chk("dn_wrap4", 32'(wrap4), 32'h1);
    en = 1'b0;
    tick();
    chk("dn_wrap4_off", 32'(wrap4), 32'h0);
    chk("en0_hold4",    32'(bin4),  32'hF);

    // Load wins over simultaneous step conditions
    en = 1'b1; up = 1'b1; out_ready = 1'b1; load = 1'b1; lb8 = 8'hA5;
    tick();
    chk("ld_bin8",  32'(bin8),  32'hA5);
    chk("ld_gray8", 32'(gray8), 32'hF7);
    chk("ld_wrap8", 32'(wrap8), 32'h0);

    // Stall with out_ready low holds the code
    lb8 = 8'h10;
    tick();
    chk("st_gray8", 32'(gray8), 32'h18);
    load = 1'b0; out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("st_hold_gray8_%0d", k), 32'(gray8), 32'h18);
      chk($sformatf("st_hold_wrap8_%0d", k), 32'(wrap8), 32'h0);
    end
    out_ready = 1'b1;
    tick();
    chk("st_res_gray8", 32'(gray8), 32'h19);
    chk("st_res_bin8",  32'(bin8),  32'h11);

    // Direction change takes effect on the very next step
    up = 1'b0;
    tick();
    chk("dir_bin8", 32'(bin8), 32'h10);
    up = 1'b1;
    tick();
    chk("dir2_bin8", 32'(bin8), 32'h11);

    // Reset mid-count at 0x7F
    load = 1'b1; lb8 = 8'h7F;
    tick();
    chk("pre_rst_bin8", 32'(bin8), 32'h7F);
    load = 1'b0; rst = 1'b1;
    tick();
    chk("mr_bin8",  32'(bin8),  32'h0);
    chk("mr_gray8", 32'(gray8), 32'h0);
    chk("mr_v8",    32'(v8),    32'h0);
    chk("mr_wrap8", 32'(wrap8), 32'h0);
    rst = 1'b0;
    tick();
    chk("mr_run_v8",   32'(v8),    32'h1);
    chk("mr_run_gray8", 32'(gray8), 32'h0);
    tick();
    chk("mr_next_bin8", 32'(bin8), 32'h1);

    // 8-bit roll-over in both directions
    load = 1'b1; lb8 = 8'hFF;
    tick();
    load = 1'b0; up = 1'b1;
    tick();
    chk("up_wrap_bin8",  32'(bin8),  32'h00);
    chk("up_wrap_wrap8", 32'(wrap8), 32'h1);
    up = 1'b0;
    tick();
    chk("dn_wrap_bin8",  32'(bin8),  32'hFF);
    chk("dn_wrap_gray8", 32'(gray8), 32'h80);
    chk("dn_wrap_wrap8", 32'(wrap8), 32'h1);

    // Randomized run against a reference model
    rst = 1'b1; load = 1'b0;
    tick();
    rst = 1'b0;
    m_b = 8'h00; m_v = 1'b0; m_w = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      en        = 1'($urandom_range(1));
      up        = 1'($urandom_range(1));
      out_ready = 1'($urandom_range(1));
      load      = ($urandom_range(15) == 0);
      lb8       = 8'($urandom);
      lb4       = 4'($urandom);
      rst       = ($urandom_range(499) == 0);
      prev_g    = gray8;
      m_step    = en & m_v & out_ready & ~load;
      if (rst) begin
        m_b = 8'h00; m_v = 1'b0; m_w = 1'b0; m_step = 1'b0;
      end else begin
        m_w = 1'b0;
        if (load) begin
          m_b = lb8;
        end else if (m_step) begin
          m_w = up ? (m_b == 8'hFF) : (m_b == 8'h00);
          m_b = up ? m_b + 8'h01 : m_b - 8'h01;
        end
        m_v = 1'b1;
      end
      tick();
      chk("rnd_bin8",  32'(bin8),  32'(m_b));
      chk("rnd_gray8", 32'(gray8), 32'(m_b ^ (m_b >> 1)));
      chk("rnd_wrap8", 32'(wrap8), 32'(m_w));
      chk("rnd_v8",    32'(v8),    32'(m_v));
      chk("rnd_gray4", 32'(gray4), 32'(bin4 ^ (bin4 >> 1)));
      if (m_step)
        chk("rnd_onebit8", 32'($countones(gray8 ^ prev_g)), 32'h1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gray_count_gen.md
GRAY_COUNT_GEN -- requirements
Module: gray_count_gen

Interface
REQ-001 SHALL have parameter SIZE, default 8, counter width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port en  input  1  count enable; stepping permitted only while high.
REQ-005 SHALL have port up  input  1  direction: 1 = increment, 0 = decrement.
REQ-006 SHALL have port load  input  1  synchronous load request.
REQ-007 SHALL have port load_bin  input  SIZE  binary value to load.
REQ-008 SHALL have port gray  output  SIZE  registered Gray code of the current count; feeds the downstream Gray-to-binary stage.
REQ-009 SHALL have port bin  output  SIZE  registered binary shadow of the current count.
REQ-010 SHALL have port out_valid  output  1  gray/bin hold a presentable code.
REQ-011 SHALL have port out_ready  input  1  downstream consumed the current code.
REQ-012 SHALL have port wrap  output  1  one-cycle pulse on terminal-count roll-over.

Function
REQ-013 SHALL hold an internal binary count B of SIZE bits; gray SHALL always equal B ^ (B >> 1) and bin SHALL always equal B, both driven from registers with no combinational path from inputs.
REQ-014 SHALL define step = en & out_valid & out_ready & ~load.
REQ-015 On step with up=1, SHALL set B <= B+1 modulo 2^SIZE; with up=0, B <= B-1 modulo 2^SIZE; the new value SHALL appear on gray/bin the following cycle (latency 1).
REQ-016 Between consecutive accepted codes, gray SHALL differ in exactly one bit, including across wrap-around in either direction.
REQ-017 wrap SHALL pulse high for exactly one cycle, coincident with the new value, when a step moves B from 2^SIZE-1 to 0 (up) or from 0 to 2^SIZE-1 (down); otherwise low.
REQ-018 load SHALL have priority over step: on load, B <= load_bin next cycle, wrap low, out_valid high, regardless of en/out_ready.
REQ-019 With no step and no load, B, gray, bin SHALL hold their values (no change while out_ready low or en low).
REQ-020 A direction change (up toggled) SHALL take effect on the very next step with no bubble or extra count.
REQ-021 out_valid SHALL be a two-state control: IDLE (low) after reset, RUN (high) from the second cycle after rst deasserts; IDLE->RUN unconditional after one cycle, RUN->IDLE only on rst.
REQ-022 Handshake: once out_valid is high, gray/bin SHALL remain stable until a cycle with out_valid & out_ready & en (or load).

Reset
REQ-023 While rst is high at a clock edge, SHALL set B=0, gray=0, bin=0, out_valid=0, wrap=0; rst SHALL override load and step.
REQ-024 Reset asserted mid-count SHALL discard count and direction history; the first valid code after reset SHALL be 0.
REQ-025 In the first cycle after rst deasserts, SHALL ignore out_ready and en (out_valid still 0), then enter RUN.

Verification
REQ-026 SIZE=4, reset then en=1,up=1,out_ready=1 for 16 steps -> gray sequence 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0; wrap pulses once at the 8->0 transition; bin = 0..15,0.
REQ-027 SIZE=4, load_bin=0 then up=0, one step -> bin=F, gray=8, wrap=1 for one cycle.
REQ-028 SIZE=8, counting up at bin=0x10, drop out_ready for 5 cycles -> gray holds 0x18, no wrap; resume -> next gray 0x19 (bin 0x11).
REQ-029 SIZE=8, load=1 and step conditions true same cycle with load_bin=0xA5 -> bin=0xA5, gray=0xF7, wrap=0.
REQ-030 SIZE=8, rst asserted while counting at bin=0x7F -> next cycle all outputs 0, out_valid low one cycle, then first accepted code is gray=0x00.
REQ-031 Random en/up/out_ready/load for 10000 cycles -> scoreboard: gray==bin^(bin>>1) every cycle, single-bit change per accepted step, wrap matches model.
